pwm_control_unit: RTL and testbench
===================================

// Module: pwm_control_unit
// PURPOSE
//   Control unit for the PWM datapath (period/active registers, down-counter, ==0 and ==ACTIVE comparators).
//   Accepts new period/active settings over a valid/ready handshake and validates them.
//   Sequences loadReg/loadCNT and generates the registered PWM output from isEq0/isEq1.
//   Applies a new setting only at a period boundary, so no PWM period is ever truncated.
// PARAMETERS
//   WIDTH  16  width of the period/active values; must match the datapath width.
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   enable     in   1      1 = generate PWM; 0 = stop at the next period boundary
//   cfgValid   in   1      periodIn/activeIn are offered
//   cfgReady   out  1      the pending slot is free; a transfer occurs when cfgValid&&cfgReady
//   periodIn   in   WIDTH  requested period P, in clk cycles
//   activeIn   in   WIDTH  requested high time A, in clk cycles
//   cfgErr     out  1      one-cycle pulse: the accepted setting was invalid and has been dropped
//   isEq0      in   1      datapath: count == 0
//   isEq1      in   1      datapath: count == ACTIVE
//   periodOut  out  WIDTH  to datapath periodIn (pending P)
//   activeOut  out  WIDTH  to datapath activeIn (pending A)
//   loadReg    out  1      datapath PERIOD/ACTIVE register load
//   loadCNT    out  1      datapath counter load (loads PERIOD-1)
//   pwmOut     out  1      PWM waveform, registered
//   running    out  1      state == RUN
// BEHAVIOUR
//   - Reset values: state=IDLE; pwmOut, loadReg, loadCNT, cfgErr, running = 0; cfgReady = 1.
//     pendValid=0, haveCfg=0, periodOut=activeOut=0. Reset mid-period stops the output immediately.
//   - Config accept (cfgValid && cfgReady):
//     valid iff P >= 2 and A < P; the setting is stored in periodOut/activeOut and pendValid is set.
//     Invalid: the setting is not stored and cfgErr=1 on the following cycle only.
//     cfgReady = !pendValid.
//   - FSM, Moore outputs unless noted:
//     IDLE: pwmOut=0.
//       enable && pendValid -> LOAD_REG.
//       enable && !pendValid && haveCfg -> LOAD_CNT.
//       Otherwise stay in IDLE.
//     LOAD_REG: loadReg=1; clear pendValid; set haveCfg -> LOAD_CNT.
//     LOAD_CNT: loadCNT=1 -> RUN.
//     RUN: on isEq1, pwmOut<=1. On isEq0, pwmOut<=0.
//       If isEq0 && enable && !pendValid: assert loadCNT combinationally in this same cycle; stay in RUN.
//       If isEq0 && enable && pendValid: -> LOAD_REG.
//       If isEq0 && !enable: -> IDLE, with no loadCNT.
//   - isEq0/isEq1 are ignored outside RUN. When both are asserted together (A=0), clear wins.
//   - Steady state: period = P cycles (count P-1..0); pwmOut high for exactly A cycles, low for P-A.
//   - Latency: a config accepted in IDLE with enable=1 at cycle n gives loadReg at n+1, loadCNT at n+2,
//     and RUN from n+3. The first rising edge of pwmOut occurs P-A cycles after entering RUN (if A>0).
//   - An update applied at a boundary inserts exactly 2 extra low cycles (LOAD_REG + LOAD_CNT).
//   - A new config accepted during RUN takes effect only at the next isEq0, never mid-period.
//     A second config is back-pressured (cfgReady=0) until LOAD_REG.
//   - Deasserting enable mid-period completes the current period, then IDLE; the setting is retained.
//     Re-enabling restarts via LOAD_CNT without any new handshake.
// TESTING
//   1. Reset; cfg P=10,A=3 with enable=1 -> loadReg@n+1, loadCNT@n+2; then pwmOut repeats 7 low/3 high.
//   2. Cfg P=1 or A=10,P=10 -> cfgErr one-cycle pulse; no loadReg; state stays IDLE.
//   3. Running P=10,A=3, send P=8,A=6 mid-period -> the current period completes;
//      then 2 extra low cycles; then 2 low/6 high.
//   4. A=0 -> pwmOut constantly 0. A=P-1 (P=5,A=4) -> 1 low/4 high.
//   5. Drop enable mid-period -> finishes that period, then IDLE with pwmOut=0.
//      Re-enable -> resumes with the same P/A via LOAD_CNT.
//   6. Assert reset during the high phase -> pwmOut=0 with no clk edge; cfgReady=1.

Source files
------------

// File: rtl/pwm_control_unit.sv
// Control unit for the PWM datapath. It accepts and validates period/active
// settings, sequences the datapath register and counter loads, and produces
// the registered PWM waveform. New settings take effect only at period
// boundaries.
module pwm_control_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfgValid,
    output logic             cfgReady,
    input  logic [WIDTH-1:0] periodIn,
    input  logic [WIDTH-1:0] activeIn,
    output logic             cfgErr,
    input  logic             isEq0,
    input  logic             isEq1,
    output logic [WIDTH-1:0] periodOut,
    output logic [WIDTH-1:0] activeOut,
    output logic             loadReg,
    output logic             loadCNT,
    output logic             pwmOut,
    output logic             running
);

    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_REG = 2'd1,
        S_LOAD_CNT = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    logic               pend_valid_q, pend_valid_d;
    logic               have_cfg_q,   have_cfg_d;
    logic [WIDTH-1:0]   period_q,     period_d;
    logic [WIDTH-1:0]   active_q,     active_d;
    logic               cfg_ready_q,  cfg_ready_d;
    logic               cfg_err_q,    cfg_err_d;
    logic               load_reg_q,   load_reg_d;
    logic               load_cnt_q,   load_cnt_d;
    logic               pwm_q,        pwm_d;
    logic               running_q,    running_d;

    logic               accept_c;
    logic               cfg_ok_c;
    logic               reload_c;

    // Handshake qualification: a transfer happens when the pending slot is free.
    always_comb begin
        accept_c = cfgValid && cfg_ready_q;
        cfg_ok_c = (periodIn >= WIDTH'(MIN_PERIOD)) && (activeIn < periodIn);
    end

    // Next-state, pending-setting and registered-output logic.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        have_cfg_d   = have_cfg_q;
        period_d     = period_q;
        active_d     = active_q;
        pwm_d        = 1'b0;
        reload_c     = 1'b0;
        cfg_err_d    = accept_c && !cfg_ok_c;

        if (accept_c && cfg_ok_c) begin
            pend_valid_d = 1'b1;
            period_d     = periodIn;
            active_d     = activeIn;
        end

        case (state_q)
            S_IDLE: begin
                // A setting accepted this very cycle starts the load immediately.
                if (enable && (pend_valid_q || (accept_c && cfg_ok_c))) begin
                    state_d = S_LOAD_REG;
                end else if (enable && have_cfg_q) begin
                    state_d = S_LOAD_CNT;
                end
            end
            S_LOAD_REG: begin
                pend_valid_d = 1'b0;
                have_cfg_d   = 1'b1;
                state_d      = S_LOAD_CNT;
            end
            S_LOAD_CNT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                pwm_d = pwm_q;
                if (isEq1) begin
                    pwm_d = 1'b1;
                end
                // Clear wins over set so that A=0 keeps the output low.
                if (isEq0) begin
                    pwm_d = 1'b0;
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (pend_valid_q) begin
                        state_d = S_LOAD_REG;
                    end else begin
                        reload_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        load_reg_d  = (state_d == S_LOAD_REG);
        load_cnt_d  = (state_d == S_LOAD_CNT);
        running_d   = (state_d == S_RUN);
        cfg_ready_d = !pend_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            have_cfg_q   <= 1'b0;
            period_q     <= '0;
            active_q     <= '0;
            cfg_ready_q  <= 1'b1;
            cfg_err_q    <= 1'b0;
            load_reg_q   <= 1'b0;
            load_cnt_q   <= 1'b0;
            pwm_q        <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            have_cfg_q   <= have_cfg_d;
            period_q     <= period_d;
            active_q     <= active_d;
            cfg_ready_q  <= cfg_ready_d;
            cfg_err_q    <= cfg_err_d;
            load_reg_q   <= load_reg_d;
            load_cnt_q   <= load_cnt_d;
            pwm_q        <= pwm_d;
            running_q    <= running_d;
        end
    end

    // The in-period counter reload is issued in the same cycle as the zero hit.
    assign cfgReady  = cfg_ready_q;
    assign cfgErr    = cfg_err_q;
    assign periodOut = period_q;
    assign activeOut = active_q;
    assign loadReg   = load_reg_q;
    assign loadCNT   = load_cnt_q | reload_c;
    assign pwmOut    = pwm_q;
    assign running   = running_q;

endmodule

// File: tb/tb_pwm_control_unit.sv
// Randomised + directed bench for pwm_control_unit with a small datapath
// model and a per-cycle scoreboard of expected outputs.
module tb_pwm_control_unit;

    localparam int unsigned W = 16;
    localparam int M_IDLE = 0;
    localparam int M_LREG = 1;
    localparam int M_LCNT = 2;
    localparam int M_RUN  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] period_in;
    logic [W-1:0] active_in;
    logic         cfg_err;
    logic         is_eq0;
    logic         is_eq1;
    logic [W-1:0] period_out;
    logic [W-1:0] active_out;
    logic         load_reg;
    logic         load_cnt;
    logic         pwm_out;
    logic         running;

    pwm_control_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfgValid  (cfg_valid),
        .cfgReady  (cfg_ready),
        .periodIn  (period_in),
        .activeIn  (active_in),
        .cfgErr    (cfg_err),
        .isEq0     (is_eq0),
        .isEq1     (is_eq1),
        .periodOut (period_out),
        .activeOut (active_out),
        .loadReg   (load_reg),
        .loadCNT   (load_cnt),
        .pwmOut    (pwm_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Datapath: PERIOD/ACTIVE registers and a down-counter that loads PERIOD-1.
    logic [W-1:0] dp_period = '0;
    logic [W-1:0] dp_active = '0;
    logic [W-1:0] dp_cnt    = '0;
    always @(posedge clk) begin
        if (load_reg) begin
            dp_period <= period_out;
            dp_active <= active_out;
        end
        if (load_cnt)
            dp_cnt <= dp_period - W'(1);
        else if (dp_cnt != '0)
            dp_cnt <= dp_cnt - W'(1);
    end
    assign is_eq0 = (dp_cnt == '0);
    assign is_eq1 = (dp_cnt == dp_active);

    typedef struct packed {
        logic         pwm;
        logic         run;
        logic         lreg;
        logic         lcnt;
        logic         err;
        logic         rdy;
        logic [W-1:0] pout;
        logic [W-1:0] aout;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;

    // Reference model: position within the current period plus the settings.
    int m_mode, m_pos, m_pc, m_ac, m_pp, m_ap;
    bit m_pend, m_have, m_err;

    function automatic void model_reset();
        m_mode = M_IDLE; m_pos = 0; m_pc = 0; m_ac = 0; m_pp = 0; m_ap = 0;
        m_pend = 1'b0; m_have = 1'b0; m_err = 1'b0;
    endfunction

    function automatic obs_t model_expect(input bit en);
        obs_t e;
        e.pwm  = (m_mode == M_RUN) && (m_pos >= m_pc - m_ac);
        e.run  = (m_mode == M_RUN);
        e.lreg = (m_mode == M_LREG);
        e.lcnt = (m_mode == M_LCNT) ||
                 ((m_mode == M_RUN) && (m_pos == m_pc - 1) && en && !m_pend);
        e.err  = m_err;
        e.rdy  = !m_pend;
        e.pout = W'(m_pp);
        e.aout = W'(m_ap);
        return e;
    endfunction

    function automatic void model_step(input bit en, input bit v, input int p, input int a);
        bit acc;
        bit ok;
        acc   = v && !m_pend;
        ok    = acc && (p >= 2) && (a < p);
        m_err = acc && !ok;
        case (m_mode)
            M_IDLE: begin
                if (en && (m_pend || ok)) m_mode = M_LREG;
                else if (en && m_have)    m_mode = M_LCNT;
            end
            M_LREG: begin
                m_pc = m_pp; m_ac = m_ap; m_pend = 1'b0; m_have = 1'b1; m_mode = M_LCNT;
            end
            M_LCNT: begin
                m_mode = M_RUN; m_pos = 0;
            end
            default: begin
                if (m_pos == m_pc - 1) begin
                    if (!en)        m_mode = M_IDLE;
                    else if (m_pend) m_mode = M_LREG;
                    else            m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        endcase
        if (ok) begin
            m_pend = 1'b1; m_pp = p; m_ap = a;
        end
    endfunction

    // Called just after a rising edge: drive this cycle's inputs and queue the expectation.
    task automatic step(input bit en, input bit v, input int p, input int a);
        enable    = en;
        cfg_valid = v;
        period_in = W'(p);
        active_in = W'(a);
        exp_q.push_back(model_expect(en));
        @(posedge clk);
        model_step(en, v, p, a);
        cycle++;
        #1;
    endtask

    task automatic idle_steps(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 0, 0);
    endtask

    function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endfunction

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    task automatic monitor();
        obs_t e;
        obs_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.pwm = pwm_out; g.run = running; g.lreg = load_reg; g.lcnt = load_cnt;
                g.err = cfg_err; g.rdy = cfg_ready; g.pout = period_out; g.aout = active_out;
                n_checks++;
                if (g === e) n_pass++;
                else $display("FAIL outputs cycle %0d: got pwm=%b run=%b lreg=%b lcnt=%b err=%b rdy=%b p=%0d a=%0d want pwm=%b run=%b lreg=%b lcnt=%b err=%b rdy=%b p=%0d a=%0d",
                              cycle, g.pwm, g.run, g.lreg, g.lcnt, g.err, g.rdy, g.pout, g.aout,
                              e.pwm, e.run, e.lreg, e.lcnt, e.err, e.rdy, e.pout, e.aout);
            end
        end
    endtask

    initial begin
        int k;
        int p;
        reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; period_in = '0; active_in = '0;
        model_reset();
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm",     W'(pwm_out),    W'(0));
        chk("rst_ready",   W'(cfg_ready),  W'(1));
        chk("rst_loadreg", W'(load_reg),   W'(0));
        chk("rst_loadcnt", W'(load_cnt),   W'(0));
        chk("rst_err",     W'(cfg_err),    W'(0));
        chk("rst_running", W'(running),    W'(0));
        chk("rst_period",  period_out,     W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Invalid settings are dropped with an error pulse
        step(1'b0, 1'b1, 1, 0);
        idle_steps(2, 1'b0);
        step(1'b1, 1'b1, 10, 10);
        idle_steps(3, 1'b1);

        // P=10, A=3 from IDLE with enable high
        step(1'b1, 1'b1, 10, 3);
        idle_steps(35, 1'b1);

        // Mid-period update to P=8, A=6
        idle_steps(4, 1'b1);
        step(1'b1, 1'b1, 8, 6);
        idle_steps(30, 1'b1);

        // A=0 then A=P-1
        step(1'b1, 1'b1, 6, 0);
        idle_steps(25, 1'b1);
        step(1'b1, 1'b1, 5, 4);
        idle_steps(20, 1'b1);

        // Drop enable mid-period, then re-enable
        idle_steps(2, 1'b1);
        idle_steps(12, 1'b0);
        idle_steps(15, 1'b1);

        // Asynchronous reset during the high phase
        k = 0;
        while (!((m_mode == M_RUN) && (m_pos >= m_pc - m_ac)) && k < 40) begin
            step(1'b1, 1'b0, 0, 0);
            k++;
        end
        chk("high_phase_reached", W'(k < 40), W'(1));
        #1;
        chk("pre_reset_pwm", W'(pwm_out), W'((m_mode == M_RUN) && (m_pos >= m_pc - m_ac)));
        reset = 1'b0;
        #1;
        chk("async_rst_pwm",     W'(pwm_out),   W'(0));
        chk("async_rst_ready",   W'(cfg_ready), W'(1));
        chk("async_rst_running", W'(running),   W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            p = $urandom_range(0, 14);
            step($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, p, $urandom_range(0, p + 1));
        end
        idle_steps(2, 1'b1);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
